ixc_xfer96_sched: RTL and testbench



---
 rtl/ixc_xfer_pkg.sv | 32 +++
 rtl/ixc_rr_pick.sv | 30 +++
 rtl/ixc_xfer96_sched.sv | 166 ++++++++++++++++
 tb/tb_ixc_xfer96_sched.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ixc_xfer_pkg.sv
// Shared types and sizing helpers for the IXCOM 96-bit transfer schedulers.
// The state encoding and width functions are reused by every scheduler variant.
package ixc_xfer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } xfer_state_e;

  localparam int XFER_DW        = 96;
  localparam int XFER_NREQ      = 4;
  localparam int XFER_MAX_BURST = 8;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  localparam int SRC_W = src_w(XFER_NREQ);
  localparam int CNT_W = cnt_w(XFER_MAX_BURST);

  // Beat as it sits in the output stage of the default 96-bit configuration.
  typedef struct packed {
    logic [XFER_DW-1:0] data;
    logic [SRC_W-1:0]   src;
    logic               last;
  } xfer_beat_t;

endpackage

// File: rtl/ixc_rr_pick.sv
// Rotate-priority picker: first asserted request at or above ptr_i, wrapping.
// Purely combinational so callers decide how and when the pointer advances.
module ixc_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = W'(j);
      end
    end
  end

endmodule

// File: rtl/ixc_xfer96_sched.sv
// Round-robin scheduler sharing one 96-bit transfer path among NREQ requesters,
// with optional burst lock and a single registered output stage.
//
// state | meaning
// IDLE  | arbitrate from ptr each cycle; single-beat grants advance ptr
// BURST | path locked to lock_q until last beat or MAX_BURST beats
module ixc_xfer96_sched
  import ixc_xfer_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 96,
  parameter int MAX_BURST = 8,
  localparam int SW       = src_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [SW-1:0]        out_src,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CW = cnt_w(MAX_BURST);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    logic          last;
  } beat_t;

  xfer_state_e     state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   lock_q, lock_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rel_q, rel_d;
  beat_t           out_q;
  logic            out_valid_q;

  logic            can_accept;
  logic            xfer;
  logic [NREQ-1:0] pick_gnt;
  logic [SW-1:0]   pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] lock_oh;
  logic [NREQ-1:0] ready;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   sel_data;
  logic            sel_last;

  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] x);
    return (x == SW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  ixc_rr_pick #(
    .N (NREQ),
    .W (SW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign can_accept = !out_valid_q || out_ready;

  // rel_q holds off arbitration for the cycle right after a burst ends.
  always_comb begin
    lock_oh = NREQ'(1) << lock_q;
    ready   = '0;
    sel     = pick_idx;
    if (state_q == IDLE) begin
      if (!rel_q && pick_any && can_accept) ready = pick_gnt;
    end else begin
      sel = lock_q;
      if (can_accept) ready = lock_oh;
    end
  end

  assign req_ready = rst_n ? ready : '0;
  assign xfer      = |(req_valid & req_ready);
  assign sel_data  = req_data[int'(sel)*DW +: DW];
  assign sel_last  = req_last[sel];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    case (state_q)
      IDLE: begin
        rel_d = 1'b0;
        if (xfer) begin
          if (sel_last || MAX_BURST == 1) begin
            ptr_d = next_idx(sel);
          end else begin
            state_d = BURST;
            lock_d  = sel;
            cnt_d   = CW'(1);
          end
        end
      end
      BURST: begin
        if (xfer) begin
          if (sel_last || (cnt_q + 1'b1) == CW'(MAX_BURST)) begin
            state_d = IDLE;
            ptr_d   = next_idx(lock_q);
            cnt_d   = '0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
    end
  end

  // Output stage keeps its last contents once drained; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (xfer) begin
      out_q.data  <= sel_data;
      out_q.src   <= sel;
      out_q.last  <= sel_last;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_src   = out_q.src;
  assign out_last  = out_q.last;
  assign busy      = (state_q == BURST) || out_valid_q;

endmodule

// File: tb/tb_ixc_xfer96_sched.sv
// Scoreboard bench for ixc_xfer96_sched: directed per-requester beat queues,
// hand-ordered expected beats, and a decoupled output monitor.
module tb_ixc_xfer96_sched;

  localparam int NREQ = 4;
  localparam int DW   = 96;
  localparam int SW   = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_last;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [SW-1:0]       out_src;
  logic                out_last;
  logic                busy;

  always #5 clk = ~clk;

  ixc_xfer96_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } rb_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } exp_t;

  rb_t             rq[NREQ][$];
  exp_t            expq[$];
  int              seen[$];
  int              cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [NREQ-1:0] hold = '0;
  logic [DW-1:0]   a5;

  function automatic logic [DW-1:0] mk(input int s, input int n);
    return {8'(s), 24'hB0B0B0, 32'(n), 32'hFACE0000 ^ 32'(s*256 + n)};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input int s, input logic [DW-1:0] d, input logic l);
    rb_t b;
    b.d = d;
    b.l = l;
    rq[s].push_back(b);
  endtask

  task automatic exp_beat(input int s, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.s = SW'(s);
    e.l = l;
    expq.push_back(e);
  endtask

  task automatic chk_gap(input string name, input int a, input int b, input int gap);
    if (seen.size() > b) begin
      chk(name, DW'(seen[b] - seen[a]), DW'(gap));
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: only %0d beats seen, required more than %0d", name, seen.size(), b);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    bit pend;
    t    = 0;
    pend = 1'b1;
    while (pend && t < 300) begin
      @(posedge clk);
      #2;
      t++;
      pend = (expq.size() != 0) || out_valid;
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) pend = 1'b1;
    end
    n_cmp++;
    if (pend) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, required 0", name, expq.size(), t);
    end
  endtask

  task automatic wait_src(input string name, input int s);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #2;
      t++;
    end while (!(out_valid && out_src == SW'(s)) && t < 50);
    n_cmp++;
    if (!(out_valid && out_src == SW'(s))) begin
      n_bad++;
      $display("FAIL %s_wait: out_valid %0b out_src %0d, required 1 and %0d", name, out_valid, out_src, s);
    end
  endtask

  always @(posedge clk) cyc++;

  // Requester drivers: pop on handshake seen before the edge, present next head after it.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      logic [NREQ-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0 && !hold[i]) begin
          req_valid[i]             = 1'b1;
          req_data[i*DW +: DW]     = rq[i][0].d;
          req_last[i]              = rq[i][0].l;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got src %0d data %0h, required no beat", out_src, out_data);
      end else begin
        e = expq.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_src", DW'(out_src), DW'(e.s));
        chk("beat_last", DW'(out_last), DW'(e.l));
        seen.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a5        = {12{8'hA5}};
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_src", DW'(out_src), '0);
    chk("rst_out_last", DW'(out_last), '0);
    chk("rst_busy", DW'(busy), '0);
    chk("rst_req_ready", DW'(req_ready), '0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Round robin over single-beat requests
    @(posedge clk);
    #2;
    seen.delete();
    for (int i = 0; i < NREQ; i++) send(i, mk(i, 0), 1'b1);
    send(0, mk(0, 1), 1'b1);
    for (int i = 0; i < NREQ; i++) exp_beat(i, mk(i, 0), 1'b1);
    exp_beat(0, mk(0, 1), 1'b1);
    wait_drain("rr");
    chk_gap("rr_gap", 0, 4, 4);

    // Burst lock for req1, ptr=1
    seen.delete();
    send(1, mk(1, 0), 1'b0);
    send(1, mk(1, 1), 1'b0);
    send(1, mk(1, 2), 1'b1);
    send(0, mk(0, 2), 1'b1);
    send(2, mk(2, 1), 1'b1);
    exp_beat(1, mk(1, 0), 1'b0);
    exp_beat(1, mk(1, 1), 1'b0);
    exp_beat(1, mk(1, 2), 1'b1);
    exp_beat(2, mk(2, 1), 1'b1);
    exp_beat(0, mk(0, 2), 1'b1);
    wait_drain("burst");
    chk_gap("burst_lock_gap", 0, 2, 2);
    chk_gap("burst_release_gap", 2, 3, 2);
    chk_gap("burst_next_gap", 3, 4, 1);

    // Forced release of req3 after 8 beats, ptr=1
    seen.delete();
    for (int n = 0; n < 10; n++) send(3, mk(3, n), (n == 9));
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) send(i, mk(i, 3), 1'b1);
    for (int n = 0; n < 8; n++) exp_beat(3, mk(3, n), 1'b0);
    for (int i = 0; i < 3; i++) exp_beat(i, mk(i, 3), 1'b1);
    exp_beat(3, mk(3, 8), 1'b0);
    exp_beat(3, mk(3, 9), 1'b1);
    wait_drain("forced");
    chk_gap("forced_run_gap", 0, 7, 7);
    chk_gap("forced_release_gap", 7, 8, 2);

    // Backpressure, ptr=0
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(1, a5, 1'b1);
    send(2, mk(2, 5), 1'b1);
    exp_beat(1, a5, 1'b1);
    exp_beat(2, mk(2, 5), 1'b1);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_out_valid", DW'(out_valid), DW'(1));
      chk("bp_out_data", out_data, a5);
      chk("bp_req_ready", DW'(req_ready), '0);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_reload_valid", DW'(out_valid), DW'(1));
    chk("bp_reload_src", DW'(out_src), DW'(2));
    chk("bp_reload_data", out_data, mk(2, 5));
    wait_drain("bp");

    // Locked bubble for req2, ptr=3
    seen.delete();
    send(2, mk(2, 6), 1'b0);
    exp_beat(2, mk(2, 6), 1'b0);
    exp_beat(2, mk(2, 7), 1'b0);
    exp_beat(2, mk(2, 8), 1'b1);
    exp_beat(0, mk(0, 6), 1'b1);
    wait_src("bubble", 2);
    hold[2] = 1'b1;
    send(2, mk(2, 7), 1'b0);
    send(2, mk(2, 8), 1'b1);
    send(0, mk(0, 6), 1'b1);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("bubble_ready0", DW'(req_ready[0]), '0);
      chk("bubble_busy", DW'(busy), DW'(1));
    end
    chk("bubble_out_valid", DW'(out_valid), '0);
    @(posedge clk);
    #2;
    hold[2] = 1'b0;
    wait_drain("bubble");
    chk_gap("bubble_resume_gap", 1, 2, 1);
    chk_gap("bubble_release_gap", 2, 3, 2);

    // Reset in the middle of a req1 burst with a beat in the output stage
    seen.delete();
    for (int n = 0; n < 4; n++) send(1, mk(1, n + 10), (n == 3));
    exp_beat(1, mk(1, 10), 1'b0);
    wait_src("midrst", 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", DW'(out_valid), '0);
    chk("midrst_out_src", DW'(out_src), '0);
    chk("midrst_busy", DW'(busy), '0);
    chk("midrst_req_ready", DW'(req_ready), '0);
    expq.delete();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(3, mk(3, 20), 1'b1);
    send(0, mk(0, 20), 1'b1);
    exp_beat(0, mk(0, 20), 1'b1);
    exp_beat(3, mk(3, 20), 1'b1);
    wait_drain("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
